// File: rtl/ycbcr_coef_ctrl.sv
// Coefficient loader and host write arbiter for the 512x8 YCbCr coefficient RAM.
// Optional build macro YCBCR_COEF_AUTOLOAD_EN: a host write into the coefficient window triggers a reload.
module ycbcr_coef_ctrl #(
    parameter int N_COEF     = 9,
    parameter int BASE_ADDR  = 0,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         host_wr_req,
    input  logic [ADDR_WIDTH-1:0]        host_wr_addr,
    input  logic [DATA_WIDTH-1:0]        host_wr_data,
    output logic                         host_wr_ack,
    input  logic                         reload,
    output logic                         busy,
    output logic                         coef_valid,
    output logic [N_COEF*DATA_WIDTH-1:0] coef_bus,
    output logic [ADDR_WIDTH-1:0]        ram_waddr,
    output logic [DATA_WIDTH-1:0]        ram_wdata,
    output logic                         ram_we,
    output logic [ADDR_WIDTH-1:0]        ram_raddr,
    output logic                         ram_re,
    input  logic [DATA_WIDTH-1:0]        ram_rdata
);

    localparam int IDX_W = (N_COEF > 1) ? $clog2(N_COEF) : 1;
    localparam int BUS_W = N_COEF * DATA_WIDTH;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(N_COEF - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_DRAIN = 2'd1,
        S_IDLE  = 2'd2,
        S_WRITE = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    pend_q, pend_d;
    logic                    cap_v_q;
    logic [IDX_W-1:0]        cap_idx_q;
    logic [BUS_W-1:0]        shadow_q;
    logic [BUS_W-1:0]        merged;
    logic [BUS_W-1:0]        coef_bus_q;
    logic                    coef_valid_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;
    logic                    autoload_hit;

`ifdef YCBCR_COEF_AUTOLOAD_EN
    logic [ADDR_WIDTH-1:0]   wr_off;

    // Unsigned offset wraps for addresses below the window, so one compare covers both bounds.
    always_comb begin
        wr_off       = wr_addr_q - BASE_A;
        autoload_hit = ({1'b0, wr_off} < (ADDR_WIDTH+1)'(N_COEF));
    end
`else
    assign autoload_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_LOAD;
            idx_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = '0;
        pend_d  = pend_q;
        case (state_q)
            S_LOAD: begin
                if (reload) pend_d = 1'b1;
                if (idx_q == LAST_IDX) state_d = S_DRAIN;
                else                   idx_d   = idx_q + 1'b1;
            end
            S_DRAIN: begin
                // A pulse landing in DRAIN itself is folded into the pending request.
                if (pend_q || reload) begin
                    state_d = S_LOAD;
                    pend_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (reload)           state_d = S_LOAD;
                else if (host_wr_req) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (pend_q || reload) begin
                    state_d = S_LOAD;
                    pend_d  = 1'b0;
                end else if (autoload_hit) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        ram_re      = (state_q == S_LOAD);
        ram_raddr   = BASE_A + ADDR_WIDTH'(idx_q);
        ram_we      = (state_q == S_WRITE);
        host_wr_ack = (state_q == S_WRITE);
    end

    // Shadow image with the byte arriving this cycle already folded in.
    always_comb begin
        merged = shadow_q;
        if (cap_v_q) begin
            for (int k = 0; k < N_COEF; k++) begin
                if (cap_idx_q == IDX_W'(k)) merged[k*DATA_WIDTH +: DATA_WIDTH] = ram_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cap_v_q      <= 1'b0;
            cap_idx_q    <= '0;
            shadow_q     <= '0;
            coef_bus_q   <= '0;
            coef_valid_q <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            cap_v_q   <= ram_re;
            cap_idx_q <= idx_q;
            if (cap_v_q) shadow_q <= merged;
            if (state_q == S_DRAIN) begin
                coef_bus_q   <= merged;
                coef_valid_q <= 1'b1;
            end
            if (state_q == S_IDLE && state_d == S_WRITE) begin
                wr_addr_q <= host_wr_addr;
                wr_data_q <= host_wr_data;
            end
        end
    end

    assign coef_bus   = coef_bus_q;
    assign coef_valid = coef_valid_q;
    assign ram_waddr  = wr_addr_q;
    assign ram_wdata  = wr_data_q;

endmodule

// File: tb/tb_ycbcr_coef_ctrl.sv
// Directed bench for ycbcr_coef_ctrl with a registered-read RAM model; follows YCBCR_COEF_AUTOLOAD_EN.
module tb_ycbcr_coef_ctrl;

    localparam logic [71:0] EXP0 = 72'h6df0282235901a9700;
    localparam logic [71:0] EXP1 = 72'h6df0282235901a8000;
    localparam logic [7:0]  INIT [0:8] = '{8'h00, 8'h97, 8'h1a, 8'h90, 8'h35, 8'h22, 8'h28, 8'hf0, 8'h6d};

    logic        clk;
    logic        resetn;
    logic        host_wr_req;
    logic [8:0]  host_wr_addr;
    logic [7:0]  host_wr_data;
    logic        host_wr_ack;
    logic        reload;
    logic        busy;
    logic        coef_valid;
    logic [71:0] coef_bus;
    logic [8:0]  ram_waddr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [8:0]  ram_raddr;
    logic        ram_re;
    logic [7:0]  ram_rdata;

    logic        mem_init;
    logic [7:0]  mem [0:511];
    logic [71:0] exp_bus;
    int          errors;
    int          checks;

    ycbcr_coef_ctrl dut (
        .clk         (clk),
        .resetn      (resetn),
        .host_wr_req (host_wr_req),
        .host_wr_addr(host_wr_addr),
        .host_wr_data(host_wr_data),
        .host_wr_ack (host_wr_ack),
        .reload      (reload),
        .busy        (busy),
        .coef_valid  (coef_valid),
        .coef_bus    (coef_bus),
        .ram_waddr   (ram_waddr),
        .ram_wdata   (ram_wdata),
        .ram_we      (ram_we),
        .ram_raddr   (ram_raddr),
        .ram_re      (ram_re),
        .ram_rdata   (ram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
            for (int i = 0; i < 9; i++) mem[i] <= INIT[i];
        end else if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        if (ram_re) ram_rdata <= mem[ram_raddr];
    end

    task automatic test_reset();
        resetn = 1'b0; mem_init = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;
        checks++; if (busy !== 1'b1 || ram_re !== 1'b1 || ram_raddr !== 9'd0) begin
            errors++; $display("FAIL reset_ctrl: busy=%b re=%b raddr=%h, want 1 1 000", busy, ram_re, ram_raddr); end
        checks++; if (coef_bus !== 72'd0 || coef_valid !== 1'b0) begin
            errors++; $display("FAIL reset_coef: bus=%h valid=%b, want 0 0", coef_bus, coef_valid); end
        checks++; if (host_wr_ack !== 1'b0 || ram_we !== 1'b0 || ram_waddr !== 9'd0 || ram_wdata !== 8'd0) begin
            errors++; $display("FAIL reset_wr: ack=%b we=%b waddr=%h wdata=%h, want 0 0 0 0", host_wr_ack, ram_we, ram_waddr, ram_wdata); end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset_load();
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk); #1;
            checks++; if (coef_bus !== 72'd0 || coef_valid !== 1'b0) begin
                errors++; $display("FAIL load_early e=%0d: bus=%h valid=%b, want 0 0", e, coef_bus, coef_valid); end
        end
        @(posedge clk); #1;
        checks++; if (coef_bus !== EXP0 || coef_valid !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL load_commit: bus=%h valid=%b busy=%b, want %h 1 0", coef_bus, coef_valid, busy, EXP0); end
        exp_bus = EXP0;
    endtask

    task automatic test_in_window_write();
        host_wr_req = 1'b1; host_wr_addr = 9'h001; host_wr_data = 8'h80;
        @(posedge clk); #1;
        checks++; if (host_wr_ack !== 1'b1 || ram_we !== 1'b1 || ram_waddr !== 9'h001 || ram_wdata !== 8'h80) begin
            errors++; $display("FAIL inwin_ack: ack=%b we=%b waddr=%h wdata=%h, want 1 1 001 80", host_wr_ack, ram_we, ram_waddr, ram_wdata); end
        host_wr_req = 1'b0;
        @(posedge clk); #1;
        checks++; if (host_wr_ack !== 1'b0 || ram_we !== 1'b0 || mem[1] !== 8'h80) begin
            errors++; $display("FAIL inwin_done: ack=%b we=%b mem1=%h, want 0 0 80", host_wr_ack, ram_we, mem[1]); end
`ifdef YCBCR_COEF_AUTOLOAD_EN
        checks++; if (busy !== 1'b1 || ram_re !== 1'b1) begin
            errors++; $display("FAIL inwin_autoload: busy=%b re=%b, want 1 1", busy, ram_re); end
        for (int e = 2; e <= 10; e++) begin
            @(posedge clk); #1;
            checks++; if (coef_bus !== EXP0 || coef_valid !== 1'b1) begin
                errors++; $display("FAIL inwin_hold e=%0d: bus=%h valid=%b, want %h 1", e, coef_bus, coef_valid, EXP0); end
        end
        @(posedge clk); #1;
        checks++; if (coef_bus !== EXP1 || busy !== 1'b0) begin
            errors++; $display("FAIL inwin_commit: bus=%h busy=%b, want %h 0", coef_bus, busy, EXP1); end
        exp_bus = EXP1;
`else
        checks++; if (busy !== 1'b0) begin
            errors++; $display("FAIL inwin_idle: busy=%b, want 0", busy); end
        repeat (11) @(posedge clk);
        #1;
        checks++; if (coef_bus !== EXP0 || ram_re !== 1'b0) begin
            errors++; $display("FAIL inwin_nochange: bus=%h re=%b, want %h 0", coef_bus, ram_re, EXP0); end
`endif
    endtask

    task automatic test_out_window_write();
        host_wr_req = 1'b1; host_wr_addr = 9'h100; host_wr_data = 8'h55;
        @(posedge clk); #1;
        checks++; if (host_wr_ack !== 1'b1 || ram_waddr !== 9'h100) begin
            errors++; $display("FAIL outwin_ack: ack=%b waddr=%h, want 1 100", host_wr_ack, ram_waddr); end
        host_wr_req = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || ram_re !== 1'b0 || mem[256] !== 8'h55 || coef_bus !== exp_bus) begin
            errors++; $display("FAIL outwin_done: busy=%b re=%b mem=%h bus=%h, want 0 0 55 %h", busy, ram_re, mem[256], coef_bus, exp_bus); end
    endtask

    task automatic test_reload_and_req();
        reload = 1'b1; host_wr_req = 1'b1; host_wr_addr = 9'h020; host_wr_data = 8'h11;
        @(posedge clk); #1;
        reload = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            checks++; if (host_wr_ack !== 1'b0) begin
                errors++; $display("FAIL simul_noack e=%0d: ack=%b, want 0", e, host_wr_ack); end
        end
        checks++; if (coef_bus !== EXP1 || busy !== 1'b0) begin
            errors++; $display("FAIL simul_commit: bus=%h busy=%b, want %h 0", coef_bus, busy, EXP1); end
        exp_bus = EXP1;
        @(posedge clk); #1;
        checks++; if (host_wr_ack !== 1'b1 || ram_waddr !== 9'h020) begin
            errors++; $display("FAIL simul_ack: ack=%b waddr=%h, want 1 020", host_wr_ack, ram_waddr); end
        host_wr_req = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || mem[32] !== 8'h11) begin
            errors++; $display("FAIL simul_done: busy=%b mem=%h, want 0 11", busy, mem[32]); end
    endtask

    task automatic test_back_to_back();
        host_wr_req = 1'b1; host_wr_addr = 9'h030; host_wr_data = 8'ha5;
        @(posedge clk); #1;
        checks++; if (host_wr_ack !== 1'b1) begin
            errors++; $display("FAIL b2b_ack1: ack=%b, want 1", host_wr_ack); end
        @(posedge clk); #1;
        checks++; if (host_wr_ack !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_gap: ack=%b busy=%b, want 0 0", host_wr_ack, busy); end
        @(posedge clk); #1;
        checks++; if (host_wr_ack !== 1'b1) begin
            errors++; $display("FAIL b2b_ack2: ack=%b, want 1", host_wr_ack); end
        host_wr_req = 1'b0;
        @(posedge clk); #1;
        checks++; if (host_wr_ack !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_end: ack=%b busy=%b, want 0 0", host_wr_ack, busy); end
    endtask

    task automatic test_reload_during_load();
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            reload = (e == 3 || e == 5);
            checks++; if (busy !== (e < 20) || ram_re !== (e != 9 && e < 19)) begin
                errors++; $display("FAIL rel_busy e=%0d: busy=%b re=%b, want %b %b", e, busy, ram_re, (e < 20), (e != 9 && e < 19)); end
            if (e == 10) begin
                checks++; if (coef_bus !== EXP1 || coef_valid !== 1'b1 || ram_raddr !== 9'd0) begin
                    errors++; $display("FAIL rel_commit1: bus=%h valid=%b raddr=%h, want %h 1 000", coef_bus, coef_valid, ram_raddr, EXP1); end
            end
        end
        checks++; if (coef_bus !== EXP1) begin
            errors++; $display("FAIL rel_commit2: bus=%h, want %h", coef_bus, EXP1); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || ram_re !== 1'b0) begin
            errors++; $display("FAIL rel_nothird: busy=%b re=%b, want 0 0", busy, ram_re); end
    endtask

    task automatic test_reset_mid();
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (ram_raddr !== 9'd4) begin
            errors++; $display("FAIL mid_idx: raddr=%h, want 004", ram_raddr); end
        resetn = 1'b0;
        #1;
        checks++; if (coef_valid !== 1'b0 || coef_bus !== 72'd0 || busy !== 1'b1 || ram_raddr !== 9'd0) begin
            errors++; $display("FAIL mid_reset: valid=%b bus=%h busy=%b raddr=%h, want 0 0 1 000", coef_valid, coef_bus, busy, ram_raddr); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk); #1;
            checks++; if (coef_bus !== 72'd0 || coef_valid !== 1'b0) begin
                errors++; $display("FAIL mid_early e=%0d: bus=%h valid=%b, want 0 0", e, coef_bus, coef_valid); end
        end
        @(posedge clk); #1;
        checks++; if (coef_bus !== EXP1 || coef_valid !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_commit: bus=%h valid=%b busy=%b, want %h 1 0", coef_bus, coef_valid, busy, EXP1); end
    endtask

    initial begin
        errors = 0; checks = 0;
        resetn = 1'b0; mem_init = 1'b1; reload = 1'b0;
        host_wr_req = 1'b0; host_wr_addr = 9'd0; host_wr_data = 8'd0;
        exp_bus = 72'd0;
        test_reset();
        test_reset_load();
        test_in_window_write();
        test_out_window_write();
        test_reload_and_req();
        test_back_to_back();
        test_reload_during_load();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ycbcr_coef_ctrl.md
# ycbcr_coef_ctrl

Sequencer and access arbiter for the 512x8 YCbCr coefficient RAM. At startup, and again on request, it fetches N_COEF bytes from a window of the RAM into shadow registers, then commits them atomically to a flat coefficient bus used by the YCbCr→RGB datapath. It also gives a host a req/ack write path into the RAM. Host writes are serialized against coefficient loads, so the RAM never sees a write and a load interleaved.

## Interface
- N_COEF, 9, number of coefficient bytes fetched per load (1..32)
- BASE_ADDR, 0, RAM address of coefficient 0; BASE_ADDR+N_COEF-1 ≤ 511
- ADDR_WIDTH, 9, RAM address width
- DATA_WIDTH, 8, RAM data width
- clk  in  1  single clock; also drives RAM wclk/rclk
- resetn  in  1  asynchronous, active-low reset
- host_wr_req  in  1  host write request; held until ack
- host_wr_addr  in  9  host write address
- host_wr_data  in  8  host write data
- host_wr_ack  out  1  one-cycle pulse; write performed this cycle
- reload  in  1  one-cycle pulse; request a coefficient reload
- busy  out  1  state ≠ IDLE
- coef_valid  out  1  coef_bus holds a complete committed set; sticky until reset
- coef_bus  out  N_COEF*8  coefficient k at bits [8k+7:8k]
- ram_waddr  out  9,  ram_wdata  out  8,  ram_we  out  1  RAM write port
- ram_raddr  out  9,  ram_re  out  1,  ram_rdata  in  8  RAM read port; data valid one edge after sampled address

## Operation
- States: LOAD, DRAIN, IDLE, WRITE. Reset state is LOAD with idx=0.
- **LOAD**
  - ram_re=1, ram_raddr=BASE_ADDR+idx (combinational).
  - Each edge increments idx. The edge sampling idx=N_COEF-1 moves the FSM to DRAIN.
- **Capture pipeline**
  - Registered cap_v<=ram_re and cap_idx<=idx.
  - When cap_v=1, shadow[cap_idx]<=ram_rdata.
- **DRAIN**
  - One cycle. Captures the last byte.
  - At the exit edge: coef_bus<=shadow with the final byte merged, and coef_valid<=1.
  - Next state is LOAD if pend_reload=1 (which clears pend_reload), otherwise IDLE.
- **IDLE**, in priority order:
  - reload=1 → LOAD, idx=0.
  - else host_wr_req=1 → WRITE; address and data are registered.
- **WRITE**
  - One cycle: ram_we=1, ram_waddr/ram_wdata from registers, host_wr_ack=1.
  - Next state is IDLE, or LOAD per Configuration.
- **reload while busy**: a reload pulse in LOAD, DRAIN or WRITE sets pend_reload. Only one pending reload is kept; further pulses merge into it.
- **Host handshake**
  - host_wr_req is ignored outside IDLE; the requester keeps waiting.
  - If req is still high in the cycle after ack, it is a new request.
  - Host address/data must stay stable while req=1.
- coef_bus changes only at the DRAIN exit edge. It never shows a partially loaded set. coef_valid never drops after it first rises (except on reset).

## Timing
- **Reset values**:
  - host_wr_ack=0, ram_we=0, ram_waddr=0, ram_wdata=0.
  - coef_bus=0, coef_valid=0.
  - busy=1, ram_re=1, ram_raddr=BASE_ADDR (state LOAD).
- **Full load**: N_COEF+1 edges from LOAD entry to commit. After reset release, commit happens at edge N_COEF+1 (edge 10 for the default).
- **Host write latency**: req sampled in IDLE at edge t → ack and ram_we high during cycle t..t+1 → RAM written at edge t+1.
- **Reset mid-operation**: resetn low forces all reset values immediately. Shadow registers and the pending flag clear, and the load restarts from idx 0 after release.
- **Simultaneous reload and host_wr_req in IDLE**: the load runs first. The write is accepted at the first IDLE after the load completes.

## Configuration
- **YCBCR_COEF_AUTOLOAD_EN defined**: a WRITE whose address lies in [BASE_ADDR, BASE_ADDR+N_COEF-1] goes straight to LOAD (idx=0) instead of IDLE. Writes outside that window return to IDLE.
- **Undefined**: WRITE always returns to IDLE, and coefficients are refreshed only by reload.
- In both cases, a pending reload takes WRITE → LOAD.

## Test plan
- **Reset load**: RAM model holds 00,97,1a,90,35,22,28,f0,6d at addresses 0..8; release resetn → at edge 10 coef_bus=0x6df0282235901a9700, coef_valid=1, busy=0. Before that edge coef_bus=0.
- **In-window write, AUTOLOAD_EN**: write addr 1, data 0x80 → ack exactly 1 cycle, ram_we 1 cycle, automatic reload → coef_bus byte1=0x80 10 edges after the WRITE cycle. coef_valid stays 1 throughout, and coef_bus changes only on the commit edge.
- **Out-of-window write, AUTOLOAD_EN**: write addr 0x100, data 0x55 → ack, busy low the next cycle, no ram_re, coef_bus unchanged. With the macro undefined, an in-window write also leaves coef_bus unchanged.
- **Simultaneous reload and req in IDLE**: assert both in the same cycle → LOAD runs 10 cycles, then WRITE, with ack 11 cycles after the request.
- **reload during LOAD**: pulse reload at LOAD idx=3 (and again at idx=5) → exactly two back-to-back loads with two commits, and busy continuous.
- **Reset mid-operation**: assert resetn low at LOAD idx=4 → coef_valid=0 and coef_bus=0 immediately. After release, a complete set commits at edge 10 with no stale shadow data.
